bin2bcd_seq: RTL



---
 rtl/bcd_pkg.sv | 29 ++
 rtl/bcd_digit_adj.sv | 16 +
 rtl/bin2bcd_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   BCD_BLANK / BCD_NINE : special digit codes (segment-decoder blank, saturate)
//   state_t              : converter FSM state encoding
//   clog2                : elaboration-time helper for the shift counter width
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_NINE  = 4'h9;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bits needed to hold values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    if (bits < 1) bits = 1;
    return bits;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Double-dabble digit correction: adds 3 to a BCD digit that is >= 5 so the
// following left shift carries correctly into the next decade.
// Ports:
//   digit    in  [3:0]  scratch BCD digit before the shift
//   adjusted out [3:0]  digit + 3 when digit >= 5, otherwise digit
// -----------------------------------------------------------------------------
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3). A start pulse in IDLE
// captures bin_in; WIDTH shift cycles later the packed BCD result appears on
// bcd_out with a one-cycle done pulse. Values above 10^DIGITS-1 saturate to
// all nines and raise ovf. bcd_out/ovf hold until the next done or reset.
//
// Parameters:
//   WIDTH  binary input width (1..32)
//   DIGITS number of BCD output digits (1..10)
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   conversion request, honoured only while busy=0
//   bin_in  in   [WIDTH-1:0]    unsigned value, sampled on the accepted start
//   busy    out  conversion in progress
//   done    out  one-cycle pulse, bcd_out/ovf updated in this cycle
//   bcd_out out  [4*DIGITS-1:0] packed BCD, digit 0 (units) in [3:0]
//   ovf     out  value did not fit in DIGITS digits (held with bcd_out)
//
// Build option:
//   BIN2BCD_LZB_EN  leading zero digits above digit 0 are output as BCD_BLANK
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic               sticky_q, sticky_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scratch_next;
  logic [BCD_W-1:0]   result_bcd;
  logic               carry;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (scratch_q[4*g +: 4]),
      .adjusted (adj[4*g +: 4])
    );
  end

  // The bit leaving the top digit is a decade the output cannot represent.
  assign carry        = adj[BCD_W-1];
  assign scratch_next = {adj[BCD_W-2:0], shift_q[WIDTH-1]};

`ifdef BIN2BCD_LZB_EN
  logic lz_leading;

  // Walk down from the top digit, blanking zeros until the first non-zero
  // digit; digit 0 always shows so a zero value reads as a single 0.
  always_comb begin
    result_bcd = scratch_next;
    lz_leading = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lz_leading && (scratch_next[4*i +: 4] == 4'h0)) begin
        result_bcd[4*i +: 4] = BCD_BLANK;
      end else begin
        lz_leading = 1'b0;
      end
    end
  end
`else
  assign result_bcd = scratch_next;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    sticky_d  = sticky_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin_in;
          scratch_d = '0;
          sticky_d  = 1'b0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        shift_d   = shift_q << 1;
        scratch_d = scratch_next;
        sticky_d  = sticky_q | carry;
        cnt_d     = cnt_q - CNT_W'(1);
        // Last shift: the freshly shifted scratch value is the result.
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (sticky_q | carry) begin
            bcd_d = {DIGITS{BCD_NINE}};
            ovf_d = 1'b1;
          end else begin
            bcd_d = result_bcd;
            ovf_d = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      sticky_q  <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      sticky_q  <= sticky_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

endmodule
